// File: rtl/pid_wb_pkg.sv
// pid_wb_pkg: shared definitions for the PID Wishbone initiator and the
// sequences that drive it.
//   - state_e        : initiator FSM states
//   - ADR_W_DEF/DAT_W_DEF : default Wishbone address/data widths
//   - PID_ADR_*      : PID slave register map
package pid_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int ADR_W_DEF = 16;
    localparam int DAT_W_DEF = 32;

    localparam logic [15:0] PID_ADR_CTRL     = 16'h0000;
    localparam logic [15:0] PID_ADR_SETPOINT = 16'h0004;
    localparam logic [15:0] PID_ADR_KP       = 16'h0008;
    localparam logic [15:0] PID_ADR_KI       = 16'h000C;
    localparam logic [15:0] PID_ADR_KD       = 16'h0010;
    localparam logic [15:0] PID_ADR_RESULT   = 16'h0020;
    localparam logic [15:0] PID_ADR_STATUS   = 16'h0024;

endpackage

// File: rtl/pid_wb_master_wb_watchdog.sv
// wb_watchdog: cycle counter for Wishbone initiators.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clr        : restart the count at 0 (takes priority over i_en)
//   i_en         : count one cycle
//   o_tc         : count has reached TIMEOUT-1
module wb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign o_tc = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Hold at terminal count so a late consumer never sees a wrapped value.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && !o_tc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pid_wb_master.sv
// pid_wb_master: Wishbone classic single-transfer initiator for the PID slave.
//   Command side : i_cmd_valid/o_cmd_ready, i_cmd_we, i_cmd_adr, i_cmd_data
//   Wishbone     : o_wb_cyc/stb/we/adr/data, i_wb_ack, i_wb_data
//   Response     : o_rsp_valid/i_rsp_ready, o_rsp_data, o_rsp_err
//   Status       : o_err_cnt, saturating count of timed-out cycles
// One Wishbone cycle per command; every output comes straight from a flop.
module pid_wb_master
    import pid_wb_pkg::*;
#(
    parameter int ADR_W    = ADR_W_DEF,
    parameter int DAT_W    = DAT_W_DEF,
    parameter int TIMEOUT  = 64,
    parameter int ERRCNT_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic                i_cmd_we,
    input  logic [ADR_W-1:0]    i_cmd_adr,
    input  logic [DAT_W-1:0]    i_cmd_data,
    output logic                o_wb_cyc,
    output logic                o_wb_stb,
    output logic                o_wb_we,
    output logic [ADR_W-1:0]    o_wb_adr,
    output logic [DAT_W-1:0]    o_wb_data,
    input  logic                i_wb_ack,
    input  logic [DAT_W-1:0]    i_wb_data,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [DAT_W-1:0]    o_rsp_data,
    output logic                o_rsp_err,
    output logic [ERRCNT_W-1:0] o_err_cnt
);

    state_e                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  wb_cyc_q, wb_cyc_d;
    logic                  wb_we_q, wb_we_d;
    logic [ADR_W-1:0]      wb_adr_q, wb_adr_d;
    logic [DAT_W-1:0]      wb_data_q, wb_data_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DAT_W-1:0]      rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [ERRCNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic wd_clr;
    logic wd_en;
    logic wd_tc;

    // Counts stb cycles without ack; terminal count marks the last stb cycle.
    wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (wd_clr),
        .i_en  (wd_en),
        .o_tc  (wd_tc)
    );

    assign wd_en = (state_q == BUS) && !i_wb_ack;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        wb_cyc_d    = wb_cyc_q;
        wb_we_d     = wb_we_q;
        wb_adr_d    = wb_adr_q;
        wb_data_d   = wb_data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        err_cnt_d   = err_cnt_q;
        wd_clr      = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    wb_we_d     = i_cmd_we;
                    wb_adr_d    = i_cmd_adr;
                    wb_data_d   = i_cmd_data;
                    wb_cyc_d    = 1'b1;
                    cmd_ready_d = 1'b0;
                    wd_clr      = 1'b1;
                    state_d     = BUS;
                end
            end
            BUS: begin
                // Ack is checked first so it beats a same-cycle timeout.
                if (i_wb_ack) begin
                    wb_cyc_d    = 1'b0;
                    rsp_data_d  = wb_we_q ? '0 : i_wb_data;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (wd_tc) begin
                    wb_cyc_d    = 1'b0;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + ERRCNT_W'(1);
                    end
                    state_d     = RESP;
                end
            end
            RESP: begin
                // cmd_ready rises here, so the next command lands one edge later.
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            wb_cyc_q    <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_adr_q    <= '0;
            wb_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            wb_cyc_q    <= wb_cyc_d;
            wb_we_q     <= wb_we_d;
            wb_adr_q    <= wb_adr_d;
            wb_data_q   <= wb_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Single-transfer classic cycles: stb always tracks cyc.
    assign o_cmd_ready = cmd_ready_q;
    assign o_wb_cyc    = wb_cyc_q;
    assign o_wb_stb    = wb_cyc_q;
    assign o_wb_we     = wb_we_q;
    assign o_wb_adr    = wb_adr_q;
    assign o_wb_data   = wb_data_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_pid_wb_master.sv
`timescale 1ns/1ps
module tb_pid_wb_master;
    import pid_wb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main instance, TIMEOUT = 8
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [15:0] cmd_adr;
    logic [31:0] cmd_data;
    logic        wb_cyc, wb_stb, wb_we, wb_ack;
    logic [15:0] wb_adr;
    logic [31:0] wb_wdata, wb_rdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic [7:0]  err_cnt;

    // Second instance, TIMEOUT = 4
    logic        c_cmd_valid, c_cmd_ready, c_cmd_we;
    logic [15:0] c_cmd_adr;
    logic [31:0] c_cmd_data;
    logic        c_wb_cyc, c_wb_stb, c_wb_we, c_wb_ack;
    logic [15:0] c_wb_adr;
    logic [31:0] c_wb_wdata, c_wb_rdata;
    logic        c_rsp_valid, c_rsp_ready, c_rsp_err;
    logic [31:0] c_rsp_data;
    logic [7:0]  c_err_cnt;

    pid_wb_master #(.TIMEOUT(8)) dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_we(cmd_we),
        .i_cmd_adr(cmd_adr), .i_cmd_data(cmd_data),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
        .o_wb_adr(wb_adr), .o_wb_data(wb_wdata),
        .i_wb_ack(wb_ack), .i_wb_data(wb_rdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data), .o_rsp_err(rsp_err), .o_err_cnt(err_cnt)
    );

    pid_wb_master #(.TIMEOUT(4)) dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(c_cmd_valid), .o_cmd_ready(c_cmd_ready), .i_cmd_we(c_cmd_we),
        .i_cmd_adr(c_cmd_adr), .i_cmd_data(c_cmd_data),
        .o_wb_cyc(c_wb_cyc), .o_wb_stb(c_wb_stb), .o_wb_we(c_wb_we),
        .o_wb_adr(c_wb_adr), .o_wb_data(c_wb_wdata),
        .i_wb_ack(c_wb_ack), .i_wb_data(c_wb_rdata),
        .o_rsp_valid(c_rsp_valid), .i_rsp_ready(c_rsp_ready),
        .o_rsp_data(c_rsp_data), .o_rsp_err(c_rsp_err), .o_err_cnt(c_err_cnt)
    );

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not finish within 2 ms");
        $fatal(1, "time limit");
    end

    // Present one command; returns #1 after the accepting edge.
    task automatic issue(input logic we, input logic [15:0] adr, input logic [31:0] data);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_data = data;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Slave model: counts stb cycles, acks in cycle ack_on (0 = never).
    // Returns at the negedge where stb is first seen low.
    task automatic bus_slave(input int ack_on, input logic [31:0] rdata,
                             output int n, output bit stable);
        n = 0; stable = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!(wb_cyc === 1'b1 && wb_stb === 1'b1)) break;
            n++;
            if (wb_adr !== cmd_adr || wb_wdata !== cmd_data || wb_we !== cmd_we) stable = 1'b0;
            wb_ack = (k == ack_on);
            wb_rdata = rdata;
        end
        wb_ack = 1'b0;
    endtask

    task automatic release_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic c_run(input int ack_on, input logic [31:0] rdata, output int n);
        @(negedge clk);
        c_cmd_valid = 1'b1; c_cmd_we = 1'b0; c_cmd_adr = PID_ADR_KI; c_cmd_data = 32'h0;
        @(posedge clk);
        #1 c_cmd_valid = 1'b0;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (c_wb_stb !== 1'b1) break;
            n++;
            c_wb_ack = (k == ack_on);
            c_wb_rdata = rdata;
        end
        c_wb_ack = 1'b0;
    endtask

    task automatic c_release();
        @(negedge clk);
        c_rsp_ready = 1'b1;
        @(posedge clk);
        #1 c_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 0; cmd_we = 0; cmd_adr = '0; cmd_data = '0; wb_ack = 0; wb_rdata = '0; rsp_ready = 0;
        c_cmd_valid = 0; c_cmd_we = 0; c_cmd_adr = '0; c_cmd_data = '0; c_wb_ack = 0; c_wb_rdata = '0; c_rsp_ready = 0;
        #12;
        checks++;
        if ({cmd_ready, wb_cyc, wb_stb, rsp_valid, rsp_err, wb_we} !== 6'b100000) begin
            errors++; $display("FAIL reset_ctrl: got %b want 100000", {cmd_ready, wb_cyc, wb_stb, rsp_valid, rsp_err, wb_we});
        end
        checks++;
        if ({wb_adr, wb_wdata, rsp_data, err_cnt} !== 88'h0) begin
            errors++; $display("FAIL reset_data: got %h want 0", {wb_adr, wb_wdata, rsp_data, err_cnt});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write();
        int n; bit st;
        issue(1'b1, PID_ADR_SETPOINT, 32'h0000_1234);
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL write_cmd_ready_drop: got %b want 0", cmd_ready); end
        bus_slave(3, 32'hFFFF_FFFF, n, st);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL write_stb_cycles: got %0d want 3", n); end
        checks++;
        if (st !== 1'b1) begin errors++; $display("FAIL write_bus_stable: got %b want 1", st); end
        checks++;
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 32'h0}) begin
            errors++; $display("FAIL write_rsp: got v=%b e=%b d=%h want v=1 e=0 d=00000000", rsp_valid, rsp_err, rsp_data);
        end
        release_rsp();
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL write_release: got %b want 01", {rsp_valid, cmd_ready}); end
    endtask

    // Edges are counted from the edge that samples cmd_valid (edge 1).
    task automatic test_read_latency();
        int e;
        e = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = PID_ADR_RESULT; cmd_data = 32'h0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin cmd_valid = 1'b0; wb_ack = 1'b1; wb_rdata = 32'hDEAD_BEEF; end
            if (rsp_valid === 1'b1) begin e = k; break; end
        end
        wb_ack = 1'b0;
        checks++;
        if (e !== 2) begin errors++; $display("FAIL read_latency_edges: got %0d want 2", e); end
        checks++;
        if ({rsp_err, rsp_data, wb_cyc} !== {1'b0, 32'hDEAD_BEEF, 1'b0}) begin
            errors++; $display("FAIL read_rsp: got e=%b d=%h cyc=%b want e=0 d=deadbeef cyc=0", rsp_err, rsp_data, wb_cyc);
        end
        release_rsp();
    endtask

    task automatic test_backpressure();
        int n, bad; bit st;
        issue(1'b0, PID_ADR_STATUS, 32'h0);
        bus_slave(2, 32'hA5A5_0F0F, n, st);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = PID_ADR_KD; cmd_data = 32'h0000_0077;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== 32'hA5A5_0F0F || rsp_err !== 1'b0 ||
                cmd_ready !== 1'b0 || wb_cyc !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL backpressure_hold: got %0d bad cycles want 0", bad); end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        checks++;
        if ({cmd_ready, rsp_valid, wb_cyc} !== 3'b100) begin
            errors++; $display("FAIL backpressure_release: got rdy/vld/cyc=%b want 100", {cmd_ready, rsp_valid, wb_cyc});
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        checks++;
        if ({wb_cyc, wb_we, wb_adr, wb_wdata} !== {1'b1, 1'b1, PID_ADR_KD, 32'h0000_0077}) begin
            errors++; $display("FAIL backpressure_next_cmd: got cyc=%b we=%b adr=%h d=%h want 1 1 0010 00000077", wb_cyc, wb_we, wb_adr, wb_wdata);
        end
        bus_slave(1, 32'h0, n, st);
        release_rsp();
    endtask

    task automatic test_timeout();
        int n; bit st;
        issue(1'b0, PID_ADR_KP, 32'h0);
        bus_slave(0, 32'hCAFE_F00D, n, st);
        checks++;
        if (n !== 8) begin errors++; $display("FAIL timeout_stb_cycles: got %0d want 8", n); end
        checks++;
        if ({rsp_valid, rsp_err, rsp_data, err_cnt} !== {1'b1, 1'b1, 32'h0, 8'd1}) begin
            errors++; $display("FAIL timeout_rsp: got v=%b e=%b d=%h cnt=%0d want 1 1 0 1", rsp_valid, rsp_err, rsp_data, err_cnt);
        end
        release_rsp();
        for (int i = 2; i <= 300; i++) begin
            issue(1'b0, PID_ADR_KP, 32'h0);
            bus_slave(0, 32'hCAFE_F00D, n, st);
            if (i == 254) begin
                checks++;
                if (err_cnt !== 8'd254) begin errors++; $display("FAIL timeout_cnt_254: got %0d want 254", err_cnt); end
            end
            if (i == 255) begin
                checks++;
                if (err_cnt !== 8'd255) begin errors++; $display("FAIL timeout_cnt_255: got %0d want 255", err_cnt); end
            end
            release_rsp();
        end
        checks++;
        if (err_cnt !== 8'd255) begin errors++; $display("FAIL timeout_cnt_saturate: got %0d want 255", err_cnt); end
    endtask

    task automatic test_collision();
        int n;
        c_run(0, 32'h1111_1111, n);
        checks++;
        if ({n == 4, c_rsp_err, c_err_cnt} !== {1'b1, 1'b1, 8'd1}) begin
            errors++; $display("FAIL collision_pre_timeout: got n=%0d e=%b cnt=%0d want 4 1 1", n, c_rsp_err, c_err_cnt);
        end
        c_release();
        c_run(4, 32'h0BAD_CAFE, n);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL collision_stb_cycles: got %0d want 4", n); end
        checks++;
        if ({c_rsp_valid, c_rsp_err, c_rsp_data, c_err_cnt} !== {1'b1, 1'b0, 32'h0BAD_CAFE, 8'd1}) begin
            errors++; $display("FAIL collision_rsp: got v=%b e=%b d=%h cnt=%0d want 1 0 0badcafe 1", c_rsp_valid, c_rsp_err, c_rsp_data, c_err_cnt);
        end
        c_release();
    endtask

    task automatic test_reset_mid_bus();
        int bad;
        issue(1'b1, PID_ADR_CTRL, 32'h0000_0001);
        @(negedge clk);
        checks++;
        if (wb_stb !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_stb: got %b want 1", wb_stb); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, wb_cyc, wb_stb, rsp_valid} !== 4'b1000) begin
            errors++; $display("FAIL rst_mid_async: got rdy/cyc/stb/vld=%b want 1000", {cmd_ready, wb_cyc, wb_stb, rsp_valid});
        end
        checks++;
        if (err_cnt !== 8'd0) begin errors++; $display("FAIL rst_mid_err_cnt: got %0d want 0", err_cnt); end
        @(negedge clk);
        rst = 1'b0;
        wb_ack = 1'b1; wb_rdata = 32'h5555_AAAA;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || wb_cyc !== 1'b0 || cmd_ready !== 1'b1) bad++;
        end
        wb_ack = 1'b0;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rst_mid_late_ack: got %0d bad cycles want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_latency();
        test_backpressure();
        test_timeout();
        test_collision();
        test_reset_mid_bus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
